// File: rtl/gcn_coo_aggregation.sv
// gcn_coo_aggregation: self-looped undirected neighbourhood sum of FM*WM rows over a COO edge list
module gcn_coo_aggregation #(
   parameter int NUM_OF_NODES    = 6,
   parameter int WEIGHT_COLS     = 3,
   parameter int DOT_PROD_WIDTH  = 16,
   parameter int COO_NUM_OF_COLS = 6,
   parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
   parameter int ROW_BW          = $clog2(NUM_OF_NODES)
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               start,
   input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]              fm_wm_row_in,
   output logic [ROW_BW-1:0]                                  fm_wm_row_addr,
   input  logic [2*COO_BW-1:0]                                coo_in,
   output logic [COO_BW-1:0]                                  coo_address,
   output logic [NUM_OF_NODES*WEIGHT_COLS*DOT_PROD_WIDTH-1:0] agg_out,
   output logic                                               done
);
   localparam int RW = WEIGHT_COLS*DOT_PROD_WIDTH;
   typedef enum logic [2:0] {IDLE, INIT, FETCH, ADD_A, ADD_B, DONE} state_t;
   state_t r_state;
   logic [RW-1:0] r_agg [NUM_OF_NODES];
   logic [ROW_BW-1:0] r_src, r_dst;
   logic [COO_BW-1:0] w_src, w_dst;
   logic [ROW_BW-1:0] w_src_row, w_dst_row, w_tgt;
   logic w_valid, w_edge_end, w_last;
   logic [RW-1:0] w_sum;
   assign w_src      = coo_in[2*COO_BW-1 -: COO_BW];
   assign w_dst      = coo_in[COO_BW-1:0];
   assign w_src_row  = ROW_BW'(w_src - COO_BW'(1));
   assign w_dst_row  = ROW_BW'(w_dst - COO_BW'(1));
   assign w_valid    = w_src != '0 && w_dst != '0 && 32'(w_src) <= NUM_OF_NODES && 32'(w_dst) <= NUM_OF_NODES;
   assign w_edge_end = (r_state == FETCH && !w_valid) || (r_state == ADD_A && r_src == r_dst) || r_state == ADD_B;
   assign w_last     = coo_address == COO_BW'(COO_NUM_OF_COLS-1);
   assign w_tgt      = (r_state == ADD_A) ? r_dst : r_src;
   // element-wise wrapping add of the fetched row onto the row being accumulated
   always_comb begin
      w_sum = '0;
      for (int c = 0; c < WEIGHT_COLS; c++)
         w_sum[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = r_agg[w_tgt][c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] + fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
   end
   // control FSM: seed rows with their own FM*WM row, then walk the edge list accumulating both endpoints
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         fm_wm_row_addr <= '0;
         coo_address    <= '0;
         done           <= 1'b0;
         r_src          <= '0;
         r_dst          <= '0;
         for (int n = 0; n < NUM_OF_NODES; n++) r_agg[n] <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_state        <= INIT;
               fm_wm_row_addr <= '0;
            end
            INIT: begin
               r_agg[fm_wm_row_addr] <= fm_wm_row_in;
               if (32'(fm_wm_row_addr) == NUM_OF_NODES-1) begin
                  r_state     <= FETCH;
                  coo_address <= '0;
               end else fm_wm_row_addr <= fm_wm_row_addr + ROW_BW'(1);
            end
            FETCH: begin
               r_src <= w_src_row;
               r_dst <= w_dst_row;
               if (w_valid) begin
                  fm_wm_row_addr <= w_src_row;
                  r_state        <= ADD_A;
               end
            end
            ADD_A: begin
               r_agg[r_dst] <= w_sum;
               if (r_src != r_dst) begin
                  fm_wm_row_addr <= r_dst;
                  r_state        <= ADD_B;
               end
            end
            ADD_B: r_agg[r_src] <= w_sum;
            DONE: if (!start) begin
               r_state <= IDLE;
               done    <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
         if (w_edge_end) begin
            if (w_last) begin
               r_state <= DONE;
               done    <= 1'b1;
            end else begin
               coo_address <= coo_address + COO_BW'(1);
               r_state     <= FETCH;
            end
         end
      end
   end
   for (genvar n = 0; n < NUM_OF_NODES; n++) begin : g_out
      assign agg_out[(NUM_OF_NODES-1-n)*RW +: RW] = r_agg[n];
   end
endmodule

// File: tb/tb_gcn_coo_aggregation.sv
// tb_gcn_coo_aggregation: randomized and directed runs checked against a behavioural aggregation model
module tb_gcn_coo_aggregation;
   localparam int N = 6, C = 3, W = 16, E = 6, CB = 3, RB = 3, AW = N*C*W, BIG = 1 << 30;
   logic clk = 1'b0, reset, start;
   logic [C*W-1:0] fm_wm_row_in;
   logic [RB-1:0] fm_wm_row_addr;
   logic [2*CB-1:0] coo_in;
   logic [CB-1:0] coo_address;
   logic [AW-1:0] agg_out;
   logic done;
   logic [W-1:0] fm [N][C];
   logic [W-1:0] ea [N][C];
   int es [E], ed [E], lit [N*C];
   logic [AW-1:0] exp_agg;
   int exp_lat = 0, k_cyc = BIG, stop_cyc = BIG, cyc = 0, total = 0, bad = 0, lat_meas = 0;
   bit model_on = 1'b0;

   gcn_coo_aggregation dut (
      .clk(clk), .reset(reset), .start(start), .fm_wm_row_in(fm_wm_row_in),
      .fm_wm_row_addr(fm_wm_row_addr), .coo_in(coo_in), .coo_address(coo_address),
      .agg_out(agg_out), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transformation result bank and COO memory, both combinational reads
   always_comb begin
      fm_wm_row_in = '0;
      coo_in = '0;
      if (int'(fm_wm_row_addr) < N)
         for (int c = 0; c < C; c++) fm_wm_row_in[(C-1-c)*W +: W] = fm[fm_wm_row_addr][c];
      if (int'(coo_address) < E) coo_in = {CB'(es[coo_address]), CB'(ed[coo_address])};
   end

   task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] pack_lit();
      logic [AW-1:0] v = '0;
      for (int i = 0; i < N*C; i++) v[(N*C-1-i)*W +: W] = W'(lit[i]);
      return v;
   endfunction

   task automatic build_model();
      for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) ea[n][c] = fm[n][c];
      exp_lat = N;
      for (int e = 0; e < E; e++) begin
         if (es[e] < 1 || es[e] > N || ed[e] < 1 || ed[e] > N) exp_lat += 1;
         else begin
            for (int c = 0; c < C; c++) ea[ed[e]-1][c] += fm[es[e]-1][c];
            if (es[e] != ed[e]) for (int c = 0; c < C; c++) ea[es[e]-1][c] += fm[ed[e]-1][c];
            exp_lat += (es[e] == ed[e]) ? 2 : 3;
         end
      end
      for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) exp_agg[(N*C-1-(n*C+c))*W +: W] = ea[n][c];
   endtask

   task automatic set_ring();
      for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) fm[n][c] = W'((n+1)*(c+1));
      es = '{1, 2, 3, 4, 5, 6};
      ed = '{2, 3, 4, 5, 6, 1};
   endtask

   task automatic start_run();
      build_model();
      k_cyc = cyc + 1;
      stop_cyc = BIG;
      start = 1'b1;
   endtask

   task automatic wait_done();
      int i = 0;
      while (!done && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk("done_seen", AW'(done), AW'(1));
      lat_meas = cyc - k_cyc;
   endtask

   task automatic drop_start();
      @(posedge clk); #1;
      start = 1'b0;
      stop_cyc = cyc + 1;
      @(posedge clk); #1;
   endtask

   // every cycle: done and the aggregated matrix must follow the model
   always @(negedge clk) if (model_on) begin
      chk("done", AW'(done), AW'(cyc >= k_cyc + exp_lat && cyc < stop_cyc));
      if (cyc >= k_cyc + exp_lat) chk("agg_out", agg_out, exp_agg);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      set_ring();
      repeat (2) @(posedge clk); #1;
      chk("rst_done", AW'(done), '0);
      chk("rst_coo_addr", AW'(coo_address), '0);
      chk("rst_row_addr", AW'(fm_wm_row_addr), '0);
      chk("rst_agg", agg_out, '0);
      reset = 1'b0;
      model_on = 1'b1;
      start_run();
      wait_done();
      chk("ring_lat", AW'(lat_meas), AW'(24));
      lit = '{9, 18, 27, 6, 12, 18, 9, 18, 27, 12, 24, 36, 15, 30, 45, 12, 24, 36};
      chk("ring_agg", agg_out, pack_lit());
      repeat (5) @(negedge clk);
      chk("hold_done", AW'(done), AW'(1));
      drop_start();
      chk("idle_done", AW'(done), '0);
      start_run();
      wait_done();
      chk("restart_lat", AW'(lat_meas), AW'(24));
      drop_start();
      es = '{1, 0, 2, 2, 2, 4};
      ed = '{1, 3, 7, 3, 3, 5};
      start_run();
      wait_done();
      chk("mixed_lat", AW'(lat_meas), AW'(19));
      lit = '{2, 4, 6, 8, 16, 24, 7, 14, 21, 9, 18, 27, 9, 18, 27, 6, 12, 18};
      chk("mixed_agg", agg_out, pack_lit());
      drop_start();
      set_ring();
      for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) fm[n][c] = 16'hFFFF;
      start_run();
      wait_done();
      for (int i = 0; i < N*C; i++) lit[i] = 'hFFFD;
      chk("wrap_agg", agg_out, pack_lit());
      drop_start();
      set_ring();
      start_run();
      while (cyc < k_cyc + 13) @(negedge clk);
      chk("mid_coo_addr", AW'(coo_address), AW'(2));
      chk("mid_row_addr", AW'(fm_wm_row_addr), AW'(2));
      model_on = 1'b0;
      #2;
      reset = 1'b1;
      start = 1'b0;
      #1;
      chk("abort_done", AW'(done), '0);
      chk("abort_coo_addr", AW'(coo_address), '0);
      chk("abort_row_addr", AW'(fm_wm_row_addr), '0);
      chk("abort_agg", agg_out, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      k_cyc = BIG;
      stop_cyc = BIG;
      model_on = 1'b1;
      @(posedge clk); #1;
      start_run();
      wait_done();
      chk("rerun_lat", AW'(lat_meas), AW'(24));
      lit = '{9, 18, 27, 6, 12, 18, 9, 18, 27, 12, 24, 36, 15, 30, 45, 12, 24, 36};
      chk("rerun_agg", agg_out, pack_lit());
      drop_start();
      for (int r = 0; r < 15; r++) begin
         for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) fm[n][c] = W'($urandom);
         for (int e = 0; e < E; e++) begin
            es[e] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, N)) : int'($urandom_range(0, 7));
            ed[e] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, N)) : int'($urandom_range(0, 7));
         end
         start_run();
         wait_done();
         chk("rand_lat", AW'(lat_meas), AW'(exp_lat));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         drop_start();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gcn_coo_aggregation.md
Name: gcn_coo_aggregation

Overview:
- Aggregation stage of the GCN datapath. Sits directly downstream of the feature×weight transformation stage and directly upstream of the per-node argmax stage.
- Walks the COO edge list one column at a time through the top-level coo_address/coo_in interface.
- Computes the self-looped, undirected neighbourhood sum of FM·WM rows: agg[n] = fm_wm[n] + Σ fm_wm[neighbour] over all edges touching n.
- Presents the full aggregated matrix plus a done flag to the argmax stage.

Parameters:
- NUM_OF_NODES, 6, graph nodes = FM·WM rows = aggregated rows
- WEIGHT_COLS, 3, columns per FM·WM row
- DOT_PROD_WIDTH, 16, width of each FM·WM element and each aggregated element
- COO_NUM_OF_COLS, 6, number of edges in the COO list
- COO_BW, $clog2(COO_NUM_OF_COLS), width of one COO node index and of coo_address
- ROW_BW, $clog2(NUM_OF_NODES), width of fm_wm_row_addr

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level; high = transformation results valid; sampled only in IDLE
- fm_wm_row_in  in  WEIGHT_COLS*DOT_PROD_WIDTH  row addressed by fm_wm_row_addr; combinational read, valid in the same cycle; element 0 in the MSBs
- fm_wm_row_addr  out  ROW_BW  registered row select into the transformation result bank
- coo_in  in  2*COO_BW  {src, dst} of edge coo_address; src in the MSBs; valid before the next rising edge
- coo_address  out  COO_BW  registered edge index into the COO memory
- agg_out  out  NUM_OF_NODES*WEIGHT_COLS*DOT_PROD_WIDTH  aggregated matrix; row 0 / element 0 in the MSBs
- done  out  1  high while in DONE; agg_out is final whenever done is high

Behaviour:
- Reset values: all outputs 0; agg storage 0; state IDLE. Reset in any state aborts immediately with no partial completion.
- Node indices in coo_in are 1-based (1..NUM_OF_NODES). An index of 0 or > NUM_OF_NODES makes the whole edge invalid.
- States:
  - IDLE:
    - On a rising edge with start=1: go to INIT, row counter r=0, fm_wm_row_addr=0.
  - INIT:
    - Each cycle: agg[r] <= fm_wm_row_in (self-loop seed); r increments; fm_wm_row_addr tracks r.
    - After NUM_OF_NODES cycles: go to FETCH with edge counter e=0 and coo_address=0.
  - FETCH:
    - Register src, dst from coo_in.
    - Valid edge: drive fm_wm_row_addr=src-1 and go to ADD_A.
    - Invalid edge: go to NEXT_EDGE handling with no accumulation.
  - ADD_A:
    - agg[dst-1] <= agg[dst-1] + fm_wm_row_in.
    - src==dst: treat as end of edge (self-loop counted once here).
    - Otherwise: drive fm_wm_row_addr=dst-1 and go to ADD_B.
  - ADD_B:
    - agg[src-1] <= agg[src-1] + fm_wm_row_in; end of edge.
  - End of edge:
    - If e == COO_NUM_OF_COLS-1: go to DONE.
    - Else: e++, coo_address=e, go to FETCH.
  - DONE:
    - done=1; agg_out held stable.
    - Return to IDLE on the first rising edge with start=0. done drops in that same transition; agg_out stays held until the next INIT.
- Latency: with start sampled at edge k and all edges valid with src≠dst, done is high after edge k + NUM_OF_NODES + 3·COO_NUM_OF_COLS (default k+24). Each self-loop edge removes 1 cycle; each invalid edge removes 2 cycles.
- start held high across DONE does not restart the block; it must fall and then rise again. start toggling outside IDLE is ignored.
- Arithmetic: element-wise unsigned add, wraps modulo 2^DOT_PROD_WIDTH, no saturation.
- Duplicate edges are accumulated each time they occur.
- agg_out is driven directly from agg storage. Rows may show partial values before done; the consumer samples agg_out only while done=1.

Test Plan:
1. Ring graph: fm_wm[i] = {i+1, 2(i+1), 3(i+1)}; edges (1,2)(2,3)(3,4)(4,5)(5,6)(6,1); start at edge k -> done at k+24; agg rows = {9,18,27}, {6,12,18}, {9,18,27}, {12,24,36}, {15,30,45}, {12,24,36}.
2. Self-loop and invalid edges: edges (1,1)(0,3)(2,7)(2,3)(2,3)(4,5); fm_wm as in test 1 -> done at k+6+2+1+1+3+3+3=k+19; agg[0]={2,4,6}, agg[1]={8,16,24}, agg[2]={7,14,21}, agg[3]={9,18,27}, agg[4]={9,18,27}, agg[5]={6,12,18}.
3. Wraparound: all fm_wm elements 16'hFFFF; ring graph of test 1 -> every agg element 16'hFFFD.
4. Handshake: start held high through DONE -> no second run and done stays 1; start low for one cycle -> IDLE with done=0; start high again -> new run, done after a further 24 cycles.
5. Reset mid-run: assert reset asynchronously while in ADD_A of edge 3 -> done, coo_address, fm_wm_row_addr and agg_out are 0 immediately, without waiting for a clock edge; a fresh run afterwards matches test 1 exactly.
